// File: rtl/vga_rd_sched.sv
// vga_rd_sched: schedules SDRAM burst reads that refill the VGA line FIFO.
//
// A new frame (frame_start) clears the FIFO and rewinds the read address. The FSM then
// issues one BURST_LEN-word read at a time whenever the FIFO has room for a whole burst.
// It stops after FRAME_WORDS words have been fetched. FIFO occupancy is tracked locally
// from the write strobes and the pixel pops.
//
// Ports
//   clk_vga      single clock, rising edge
//   vga_rst      asynchronous active-low reset
//   frame_start  one-cycle pulse at vsync falling edge
//   vga_rden     pixel word popped from the FIFO this cycle
//   rd_req       burst read request (held until rd_ack)
//   rd_addr      burst start word address
//   rd_ack       one-cycle request acceptance
//   rd_valid     one returned burst word this cycle
//   fifo_wr      FIFO write strobe (rd_valid qualified by WAIT)
//   fifo_clr     FIFO synchronous clear
//   fifo_level   tracked FIFO occupancy
//   frame_done   every word of the current frame has been fetched
//   underflow    sticky: pop seen while fifo_level was zero
module vga_rd_sched #(
  parameter logic [21:0] BASE_ADDR   = 22'h000000,
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned FRAME_WORDS = 307200
) (
  input  logic        clk_vga,
  input  logic        vga_rst,
  input  logic        frame_start,
  input  logic        vga_rden,
  output logic        rd_req,
  output logic [21:0] rd_addr,
  input  logic        rd_ack,
  input  logic        rd_valid,
  output logic        fifo_wr,
  output logic        fifo_clr,
  output logic [9:0]  fifo_level,
  output logic        frame_done,
  output logic        underflow
);

  localparam int unsigned    BcW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BcW-1:0] BurstLast = BcW'(BURST_LEN - 1);
  localparam logic [18:0]    FrameLast = 19'(FRAME_WORDS - 1);
  localparam logic [9:0]     ReqThresh = 10'(FIFO_DEPTH - BURST_LEN);
  localparam logic [21:0]    AddrStep  = 22'(BURST_LEN);

  typedef enum logic [2:0] {StIdle, StFlush, StCheck, StReq, StWait, StDone} state_e;

  state_e         state_q, state_d;
  logic           rd_req_q, rd_req_d;
  logic [21:0]    rd_addr_q, rd_addr_d;
  logic [9:0]     level_q, level_d;
  logic           frame_done_q, frame_done_d;
  logic           underflow_q, underflow_d;
  logic           pending_q, pending_d;
  logic [BcW-1:0] burst_cnt_q, burst_cnt_d;
  logic [18:0]    word_cnt_q, word_cnt_d;

  assign fifo_wr    = (state_q == StWait) && rd_valid;
  assign fifo_clr   = (state_q == StFlush);
  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign fifo_level = level_q;
  assign frame_done = frame_done_q;
  assign underflow  = underflow_q;

  always_comb begin
    state_d      = state_q;
    rd_req_d     = rd_req_q;
    rd_addr_d    = rd_addr_q;
    level_d      = level_q;
    frame_done_d = frame_done_q;
    underflow_d  = underflow_q;
    pending_d    = pending_q;
    burst_cnt_d  = burst_cnt_q;
    word_cnt_d   = word_cnt_q;

    // Simultaneous write and pop cancel; a pop from empty leaves the level at zero.
    if (fifo_wr && !vga_rden) begin
      level_d = level_q + 10'd1;
    end else if (!fifo_wr && vga_rden && (level_q != 10'd0)) begin
      level_d = level_q - 10'd1;
    end
    if (vga_rden && (level_q == 10'd0)) begin
      underflow_d = 1'b1;
    end

    // A new frame cannot interrupt a burst in flight; remember it for later.
    if (((state_q == StReq) || (state_q == StWait)) && frame_start) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (frame_start) state_d = StFlush;
      end
      StFlush: begin
        level_d      = 10'd0;
        rd_addr_d    = BASE_ADDR;
        word_cnt_d   = 19'd0;
        burst_cnt_d  = '0;
        frame_done_d = 1'b0;
        pending_d    = 1'b0;
        state_d      = StCheck;
      end
      StCheck: begin
        if (frame_start) begin
          state_d = StFlush;
        end else if (level_q <= ReqThresh) begin
          state_d  = StReq;
          rd_req_d = 1'b1;
        end
      end
      StReq: begin
        if (rd_ack) begin
          rd_req_d  = 1'b0;
          rd_addr_d = rd_addr_q + AddrStep;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (rd_valid) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          word_cnt_d  = word_cnt_q + 19'd1;
          if (burst_cnt_q == BurstLast) begin
            burst_cnt_d = '0;
            if (word_cnt_q == FrameLast) begin
              state_d      = StDone;
              frame_done_d = 1'b1;
            end else if (pending_q || frame_start) begin
              state_d = StFlush;
            end else begin
              state_d = StCheck;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_vga or negedge vga_rst) begin
    if (!vga_rst) begin
      state_q      <= StIdle;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= BASE_ADDR;
      level_q      <= 10'd0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
      pending_q    <= 1'b0;
      burst_cnt_q  <= '0;
      word_cnt_q   <= 19'd0;
    end else begin
      state_q      <= state_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      level_q      <= level_d;
      frame_done_q <= frame_done_d;
      underflow_q  <= underflow_d;
      pending_q    <= pending_d;
      burst_cnt_q  <= burst_cnt_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_vga_rd_sched.sv
// Directed bench for vga_rd_sched: a cycle table for the first transaction and level
// arithmetic, then hand sequences for bursts, FIFO fill, mid-burst frame_start,
// asynchronous reset and a complete (shortened) frame.
module tb_vga_rd_sched;

  localparam int unsigned BL = 64;
  localparam int unsigned FD = 512;
  // Shortened frame: 40 bursts keep the run brief while exercising the frame end.
  localparam int unsigned FW = 2560;

  logic        clk_vga = 1'b0;
  logic        vga_rst;
  logic        frame_start, vga_rden, rd_ack, rd_valid;
  logic        rd_req, fifo_wr, fifo_clr, frame_done, underflow;
  logic [21:0] rd_addr;
  logic [9:0]  fifo_level;

  logic tab_fs, tab_rden, tab_ack, tab_valid;
  logic resp_ack, resp_valid, pop_rden;
  logic auto_en, pop_en, pop_done;

  assign frame_start = tab_fs;
  assign vga_rden    = tab_rden | pop_rden;
  assign rd_ack      = tab_ack | resp_ack;
  assign rd_valid    = tab_valid | resp_valid;

  always #5 clk_vga = ~clk_vga;

  vga_rd_sched #(
    .BASE_ADDR  (22'h000000),
    .BURST_LEN  (BL),
    .FIFO_DEPTH (FD),
    .FRAME_WORDS(FW)
  ) dut (
    .clk_vga    (clk_vga),
    .vga_rst    (vga_rst),
    .frame_start(frame_start),
    .vga_rden   (vga_rden),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .fifo_wr    (fifo_wr),
    .fifo_clr   (fifo_clr),
    .fifo_level (fifo_level),
    .frame_done (frame_done),
    .underflow  (underflow)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Monitor: accepted requests and FIFO writes.
  int          burst_n = 0;
  int          wr_n    = 0;
  logic [21:0] addr_log [256];

  always @(negedge clk_vga) begin
    if (rd_req && rd_ack) begin
      addr_log[burst_n % 256] <= rd_addr;
      burst_n                 <= burst_n + 1;
    end
    if (fifo_wr) wr_n <= wr_n + 1;
  end

  // Auto responder: ack three cycles after a request is seen, then BL data words.
  initial begin
    resp_ack   = 1'b0;
    resp_valid = 1'b0;
    forever begin
      @(posedge clk_vga); #1;
      if (auto_en && rd_req) begin
        repeat (2) begin @(posedge clk_vga); #1; end
        resp_ack = 1'b1;
        @(posedge clk_vga); #1;
        resp_ack = 1'b0;
        repeat (BL) begin
          resp_valid = 1'b1;
          @(posedge clk_vga); #1;
        end
        resp_valid = 1'b0;
      end
    end
  end

  // Pixel consumer: 640 pops per 800-cycle line, FW pops in total, starting from a full FIFO.
  initial begin
    int phase;
    int pops;
    pop_rden = 1'b0;
    pop_done = 1'b0;
    phase    = 0;
    pops     = 0;
    wait (pop_en);
    wait (fifo_level == 10'(FD));
    @(posedge clk_vga); #1;
    while (pops < FW) begin
      pop_rden = (phase < 640);
      if (pop_rden) pops++;
      phase = (phase == 799) ? 0 : phase + 1;
      @(posedge clk_vga); #1;
    end
    pop_rden = 1'b0;
    pop_done = 1'b1;
  end

  task automatic tick();
    @(posedge clk_vga); #1;
  endtask

  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      tab_valid = 1'b1;
      tick();
    end
    tab_valid = 1'b0;
  endtask

  task automatic ack_once();
    tab_ack = 1'b1;
    tick();
    tab_ack = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (!rd_req && k < 50) begin
      tick();
      k++;
    end
    check(name, {31'd0, rd_req}, 32'd1);
  endtask

  typedef struct packed {
    logic        fs, rden, ack, valid;
    logic        exp_wr;
    logic        exp_req, exp_clr, exp_uf;
    logic [9:0]  exp_lvl;
    logic [21:0] exp_addr;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int b0, w0, w1, k, req_seen;

    //            fs    rden  ack   valid wr    req   clr   uf    level  addr
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 22'd0};  // valid in IDLE
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 22'd0};  // -> FLUSH
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 22'd0};  // CHECK
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 22'd0};  // REQ
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 22'd0};  // valid in REQ
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 22'd64}; // ack
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd1, 22'd64};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd1, 22'd64}; // wr+pop
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 22'd64};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 22'd64}; // pop at 0
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'd1, 22'd64};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd1, 22'd64}; // sticky

    vga_rst   = 1'b0;
    tab_fs    = 1'b0;
    tab_rden  = 1'b0;
    tab_ack   = 1'b0;
    tab_valid = 1'b0;
    auto_en   = 1'b0;
    pop_en    = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_rd_req", {31'd0, rd_req}, 32'd0);
    check("rst_rd_addr", {10'd0, rd_addr}, 32'd0);
    check("rst_level", {22'd0, fifo_level}, 32'd0);
    check("rst_flags", {28'd0, fifo_wr, fifo_clr, frame_done, underflow}, 32'd0);
    vga_rst = 1'b1;

    // Cycle table: first transaction, ignored rd_valid, level arithmetic, underflow
    for (int i = 0; i < 12; i++) begin
      tab_fs    = vecs[i].fs;
      tab_rden  = vecs[i].rden;
      tab_ack   = vecs[i].ack;
      tab_valid = vecs[i].valid;
      #1;
      check($sformatf("v%0d_fifo_wr", i), {31'd0, fifo_wr}, {31'd0, vecs[i].exp_wr});
      tick();
      tab_fs    = 1'b0;
      tab_rden  = 1'b0;
      tab_ack   = 1'b0;
      tab_valid = 1'b0;
      check($sformatf("v%0d_rd_req", i), {31'd0, rd_req}, {31'd0, vecs[i].exp_req});
      check($sformatf("v%0d_fifo_clr", i), {31'd0, fifo_clr}, {31'd0, vecs[i].exp_clr});
      check($sformatf("v%0d_underflow", i), {31'd0, underflow}, {31'd0, vecs[i].exp_uf});
      check($sformatf("v%0d_level", i), {22'd0, fifo_level}, {22'd0, vecs[i].exp_lvl});
      check($sformatf("v%0d_rd_addr", i), {10'd0, rd_addr}, {10'd0, vecs[i].exp_addr});
    end

    // Finish burst 0 (3 words so far), then second burst to level 100 and a wr+pop cycle
    feed(61);
    check("b0_level", {22'd0, fifo_level}, 32'd62);
    wait_req("b1_req");
    check("b1_addr", {10'd0, rd_addr}, 32'd64);
    ack_once();
    feed(38);
    check("lvl100", {22'd0, fifo_level}, 32'd100);
    tab_valid = 1'b1;
    tab_rden  = 1'b1;
    #1;
    check("lvl100_wr", {31'd0, fifo_wr}, 32'd1);
    tick();
    tab_valid = 1'b0;
    tab_rden  = 1'b0;
    check("lvl100_both", {22'd0, fifo_level}, 32'd100);
    check("uf_persist", {31'd0, underflow}, 32'd1);
    feed(25);
    check("b1_level", {22'd0, fifo_level}, 32'd125);
    wait_req("b2_req");

    // Asynchronous reset while rd_req is high
    #2;
    vga_rst = 1'b0;
    #1;
    check("async_rd_req", {31'd0, rd_req}, 32'd0);
    check("async_level", {22'd0, fifo_level}, 32'd0);
    check("async_uf", {31'd0, underflow}, 32'd0);
    check("async_addr", {10'd0, rd_addr}, 32'd0);
    tick();
    tick();
    vga_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tab_valid = 1'b1;
      #1;
      check($sformatf("post_rst_wr%0d", i), {31'd0, fifo_wr}, 32'd0);
      tick();
    end
    tab_valid = 1'b0;
    check("post_rst_level", {22'd0, fifo_level}, 32'd0);
    check("post_rst_req", {31'd0, rd_req}, 32'd0);

    // Fill with no pops: 8 bursts, then no further request at level FD
    b0      = burst_n;
    w0      = wr_n;
    auto_en = 1'b1;
    tab_fs  = 1'b1;
    tick();
    tab_fs = 1'b0;
    k = 0;
    while (!((burst_n - b0) == 8 && fifo_level == 10'(FD)) && k < 3000) begin
      tick();
      k++;
    end
    req_seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (rd_req) req_seen++;
      tick();
    end
    check("fill_req_cycles", req_seen, 32'd0);
    check("fill_bursts", burst_n - b0, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill_addr%0d", i), {10'd0, addr_log[(b0 + i) % 256]}, i * BL);
    end
    check("fill_wr_count", wr_n - w0, 32'(FD));
    check("fill_level", {22'd0, fifo_level}, 32'(FD));
    auto_en = 1'b0;

    // frame_start in WAIT after 20 words: burst completes, then FLUSH, then restart at 0
    tab_fs = 1'b1;
    tick();
    tab_fs = 1'b0;
    wait_req("pend_req");
    check("pend_addr", {10'd0, rd_addr}, 32'd0);
    ack_once();
    feed(20);
    tab_fs = 1'b1;
    tick();
    tab_fs = 1'b0;
    check("pend_no_clr", {31'd0, fifo_clr}, 32'd0);
    w1 = wr_n;
    feed(44);
    check("pend_wr44", wr_n - w1, 32'd44);
    check("pend_clr", {31'd0, fifo_clr}, 32'd1);
    check("pend_level64", {22'd0, fifo_level}, 32'd64);
    tick();
    check("pend_level0", {22'd0, fifo_level}, 32'd0);
    wait_req("pend_next_req");
    check("pend_next_addr", {10'd0, rd_addr}, 32'd0);

    // Full (shortened) frame with 640-of-800 pops
    b0      = burst_n;
    w0      = wr_n;
    auto_en = 1'b1;
    pop_en  = 1'b1;
    k = 0;
    while (!(pop_done && frame_done) && k < 20000) begin
      tick();
      k++;
    end
    tick();
    check("frame_bursts", burst_n - b0, FW / BL);
    check("frame_last_addr", {10'd0, addr_log[(burst_n - 1) % 256]}, FW - BL);
    check("frame_done", {31'd0, frame_done}, 32'd1);
    check("frame_uf", {31'd0, underflow}, 32'd0);
    check("frame_wr_count", wr_n - w0, FW);
    check("frame_level", {22'd0, fifo_level}, 32'd0);
    check("frame_no_req", {31'd0, rd_req}, 32'd0);
    auto_en = 1'b0;

    // frame_done holds in DONE and clears through FLUSH
    repeat (5) tick();
    check("done_hold", {31'd0, frame_done}, 32'd1);
    tab_fs = 1'b1;
    tick();
    tab_fs = 1'b0;
    check("done_flush", {31'd0, fifo_clr}, 32'd1);
    tick();
    check("done_clear", {31'd0, frame_done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
